lifo_arb: RTL and testbench

- Shares one lifo stack between N_REQ requesters.
- Performs round-robin arbitration of push/pop requests and drives the stack's write/read strobes.
- Returns popped data, or an overflow/underflow error, tagged with the requester ID one cycle after the grant.
- Provides a flush sequence that drains the stack to empty. Sits between the requesting blocks and the lifo instance.

---
 rtl/lifo_arb.sv | 169 ++++++++++++++++
 tb/tb_lifo_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_arb.sv
// Round-robin arbiter sharing one lifo stack between N_REQ requesters.
// Pushes/pops are granted one per cycle; tagged responses follow one cycle after the grant.
module lifo_arb #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 10,
    parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_push,
    input  logic [N_REQ-1:0]        req_pop,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    input  logic                    flush,
    output logic                    flush_busy,
    output logic                    lifo_write,
    output logic                    lifo_read,
    output logic [DATA_W-1:0]       lifo_datain,
    input  logic [DATA_W-1:0]       lifo_dataout,
    input  logic                    lifo_full,
    input  logic                    lifo_empty
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              flush_busy_q, flush_busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;
    logic              pop_ok_q, pop_ok_d;

    logic [N_REQ-1:0]  eligible_s;
    logic              found_s;
    logic [ID_W-1:0]   winner_s;

    // Rotating priority search: lowest offset from rr_ptr among eligible requesters wins.
    always_comb begin
        int idx;
        idx        = 0;
        eligible_s = req_push | req_pop;
        found_s    = 1'b0;
        winner_s   = {ID_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (eligible_s[idx]) begin
                found_s  = 1'b1;
                winner_s = ID_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state, grant and stack strobe decode; everything stays idle while reset is high.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        flush_busy_d = flush_busy_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = 1'b0;
        pop_ok_d     = 1'b0;
        gnt          = {N_REQ{1'b0}};
        lifo_write   = 1'b0;
        lifo_read    = 1'b0;
        lifo_datain  = {DATA_W{1'b0}};
        if (reset) begin
            state_d = ST_ARB;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (flush) begin
                        state_d      = ST_FLUSH;
                        flush_busy_d = 1'b1;
                    end else if (found_s) begin
                        gnt[winner_s] = 1'b1;
                        rsp_valid_d   = 1'b1;
                        rsp_id_d      = winner_s;
                        if (winner_s == ID_W'(N_REQ - 1)) begin
                            rr_ptr_d = {ID_W{1'b0}};
                        end else begin
                            rr_ptr_d = winner_s + ID_W'(1'b1);
                        end
                        // Push takes precedence; a simultaneous pop waits for a later round.
                        if (req_push[winner_s]) begin
                            if (!lifo_full) begin
                                lifo_write  = 1'b1;
                                lifo_datain = req_data[int'(winner_s)*DATA_W +: DATA_W];
                            end else begin
                                rsp_err_d = 1'b1;
                            end
                        end else begin
                            if (!lifo_empty) begin
                                lifo_read = 1'b1;
                                pop_ok_d  = 1'b1;
                            end else begin
                                rsp_err_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d = ST_ARB;
                    end
                end
                ST_FLUSH: begin
                    if (lifo_empty) begin
                        state_d      = ST_ARB;
                        flush_busy_d = 1'b0;
                    end else begin
                        lifo_read = 1'b1;
                    end
                end
                default: begin
                    state_d      = ST_ARB;
                    flush_busy_d = 1'b0;
                end
            endcase
        end
    end

    // State, round-robin pointer and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ARB;
            rr_ptr_q     <= {ID_W{1'b0}};
            flush_busy_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= {ID_W{1'b0}};
            rsp_err_q    <= 1'b0;
            pop_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            flush_busy_q <= flush_busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            pop_ok_q     <= pop_ok_d;
        end
    end

    // Stack output is itself registered, so popped data is steered straight through.
    always_comb begin
        if (pop_ok_q) begin
            rsp_data = lifo_dataout;
        end else begin
            rsp_data = {DATA_W{1'b0}};
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign flush_busy = flush_busy_q;

endmodule

// File: tb/tb_lifo_arb.sv
// Directed bench for lifo_arb with a 6-deep behavioural stack attached to its lifo ports.
module tb_lifo_arb;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 10;
    localparam int ID_W   = 1;
    localparam int DEPTH  = 6;

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req_push;
    logic [N_REQ-1:0]        req_pop;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    flush;
    logic                    flush_busy;
    logic                    lifo_write;
    logic                    lifo_read;
    logic [DATA_W-1:0]       lifo_datain;
    logic [DATA_W-1:0]       lifo_dataout;
    logic                    lifo_full;
    logic                    lifo_empty;

    int checks;
    int errors;

    lifo_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_push(req_push), .req_pop(req_pop), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush(flush), .flush_busy(flush_busy),
        .lifo_write(lifo_write), .lifo_read(lifo_read),
        .lifo_datain(lifo_datain), .lifo_dataout(lifo_dataout),
        .lifo_full(lifo_full), .lifo_empty(lifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: registered dataout, flags reflect post-edge occupancy.
    logic [DATA_W-1:0] mem [DEPTH];
    int                cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= 0;
            lifo_dataout <= '0;
        end else if (lifo_write && cnt < DEPTH) begin
            mem[cnt] <= lifo_datain;
            cnt      <= cnt + 1;
        end else if (lifo_read && cnt > 0) begin
            lifo_dataout <= mem[cnt-1];
            cnt          <= cnt - 1;
        end
    end
    assign lifo_full  = (cnt == DEPTH);
    assign lifo_empty = (cnt == 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go;
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point of the current cycle and check the strobe exclusivity.
    task automatic mid;
        @(negedge clk);
        chk("wr_rd_exclusive", 32'(lifo_write & lifo_read), 32'd0);
    endtask

    task automatic do_reset;
        go;
        reset    = 1'b1;
        req_push = '0;
        req_pop  = '0;
        flush    = 1'b0;
        go;
        reset    = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic [ID_W-1:0] id,
                           input logic err, input logic [DATA_W-1:0] data);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_err"},   32'(rsp_err),   32'(err));
        chk({tag, "_data"},  32'(rsp_data),  32'(data));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        req_pop  = '0;
        req_push = 2'b01;
        req_data = '0;

        // Reset state, with a request present to show gnt is forced low.
        mid;
        chk("rst_gnt",        32'(gnt),        32'd0);
        chk("rst_write",      32'(lifo_write), 32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("rst_rsp_data",   32'(rsp_data),   32'd0);
        chk("rst_rsp_err",    32'(rsp_err),    32'd0);
        chk("rst_flush_busy", 32'(flush_busy), 32'd0);

        // Single push from requester 0.
        go;
        reset    = 1'b0;
        req_data = {10'h000, 10'h155};
        mid;
        chk("p1_gnt",    32'(gnt),         32'h1);
        chk("p1_write",  32'(lifo_write),  32'd1);
        chk("p1_datain", 32'(lifo_datain), 32'h155);
        go;
        req_push = '0;
        mid;
        chk_rsp("p1_rsp", 1'b0, 1'b0, 10'h000);
        chk("p1_gnt_idle", 32'(gnt), 32'd0);

        // Both push continuously: alternating grants, 7th push overflows.
        do_reset;
        req_push = 2'b11;
        req_data = {10'h011, 10'h010};
        for (int k = 0; k < 8; k++) begin
            mid;
            if (k < 7) begin
                chk($sformatf("rr_gnt%0d", k),   32'(gnt),        (k % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("rr_write%0d", k), 32'(lifo_write), (k < 6) ? 32'd1 : 32'd0);
            end
            if (k < 2) begin
                chk($sformatf("rr_datain%0d", k), 32'(lifo_datain), (k == 0) ? 32'h010 : 32'h011);
            end
            if (k >= 1) begin
                chk_rsp($sformatf("rr_rsp%0d", k - 1), ID_W'((k - 1) % 2), (k - 1 == 6), 10'h000);
            end
            go;
        end
        req_push = '0;

        // Push 1,2,3 from requester 0, then pop four times from requester 1.
        do_reset;
        req_push = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            req_data = {10'h000, 10'(k)};
            mid;
            chk($sformatf("lp_push_gnt%0d", k), 32'(gnt), 32'h1);
            go;
        end
        req_push = '0;
        req_pop  = 2'b10;
        for (int p = 0; p < 5; p++) begin
            mid;
            if (p < 4) begin
                chk($sformatf("lp_pop_gnt%0d", p),  32'(gnt),       32'h2);
                chk($sformatf("lp_pop_read%0d", p), 32'(lifo_read), (p < 3) ? 32'd1 : 32'd0);
            end
            if (p == 0) begin
                chk_rsp("lp_push3_rsp", 1'b0, 1'b0, 10'h000);
            end else begin
                chk_rsp($sformatf("lp_pop_rsp%0d", p - 1), 1'b1, (p == 4),
                        (p == 4) ? 10'h000 : 10'(4 - p));
            end
            go;
            if (p == 3) begin
                req_pop = '0;
            end
        end

        // Push and pop together: push first, pop later returns the pushed word.
        do_reset;
        req_push = 2'b01;
        req_pop  = 2'b01;
        req_data = {10'h000, 10'h0AA};
        mid;
        chk("pp_gnt0",  32'(gnt),        32'h1);
        chk("pp_write", 32'(lifo_write), 32'd1);
        chk("pp_read0", 32'(lifo_read),  32'd0);
        go;
        req_push = '0;
        mid;
        chk("pp_gnt1", 32'(gnt),       32'h1);
        chk("pp_read", 32'(lifo_read), 32'd1);
        chk_rsp("pp_push_rsp", 1'b0, 1'b0, 10'h000);
        go;
        req_pop = '0;
        mid;
        chk_rsp("pp_pop_rsp", 1'b0, 1'b0, 10'h0AA);

        // Four entries, flush with a pop held: drain, then pop underflows.
        do_reset;
        req_push = 2'b10;
        for (int k = 0; k < 4; k++) begin
            req_data = {10'(10'h101 + k), 10'h000};
            mid;
            chk($sformatf("fl_push_gnt%0d", k), 32'(gnt), 32'h2);
            go;
        end
        req_push = '0;
        flush    = 1'b1;
        req_pop  = 2'b01;
        mid;
        chk("fl0_gnt",  32'(gnt),        32'd0);
        chk("fl0_read", 32'(lifo_read),  32'd0);
        chk("fl0_busy", 32'(flush_busy), 32'd0);
        chk_rsp("fl0_owed_rsp", 1'b1, 1'b0, 10'h000);
        go;
        flush = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            mid;
            chk($sformatf("fl%0d_gnt", k),   32'(gnt),        32'd0);
            chk($sformatf("fl%0d_read", k),  32'(lifo_read),  (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("fl%0d_busy", k),  32'(flush_busy), 32'd1);
            chk($sformatf("fl%0d_valid", k), 32'(rsp_valid),  32'd0);
            go;
        end
        mid;
        chk("fl6_busy", 32'(flush_busy), 32'd0);
        chk("fl6_gnt",  32'(gnt),        32'h1);
        chk("fl6_read", 32'(lifo_read),  32'd0);
        go;
        req_pop = '0;
        mid;
        chk_rsp("fl7_rsp", 1'b0, 1'b1, 10'h000);

        // Reset in the middle of a flush with two entries left.
        do_reset;
        req_push = 2'b01;
        for (int k = 0; k < 4; k++) begin
            req_data = {10'h000, 10'(10'h020 + k)};
            go;
        end
        req_push = '0;
        flush    = 1'b1;
        go;
        flush = 1'b0;
        mid;
        chk("mr_f1_busy", 32'(flush_busy), 32'd1);
        chk("mr_f1_read", 32'(lifo_read),  32'd1);
        go;
        go;
        reset    = 1'b1;
        req_push = 2'b11;
        mid;
        chk("mr_busy",  32'(flush_busy), 32'd0);
        chk("mr_read",  32'(lifo_read),  32'd0);
        chk("mr_valid", 32'(rsp_valid),  32'd0);
        chk("mr_gnt",   32'(gnt),        32'd0);
        go;
        reset = 1'b0;
        mid;
        chk("mr_first_gnt",   32'(gnt),        32'h1);
        chk("mr_first_write", 32'(lifo_write), 32'd1);
        go;
        req_push = '0;
        mid;
        chk_rsp("mr_first_rsp", 1'b0, 1'b0, 10'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
